sd_resp_rx_param: RTL and testbench



---
 rtl/sd_pkg.sv | 24 ++
 rtl/sd_crc7.sv | 33 +++
 rtl/sd_resp_rx_param.sv | 206 ++++++++++++++++++++
 tb/tb_sd_resp_rx_param.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared encodings for the SD CMD-line blocks: response types, receiver states, CRC7 polynomial.
// SD_RESP_BUSY_EN adds the R1b busy-wait state.
package sd_pkg;

    localparam logic [1:0] RESP_NONE        = 2'd0;
    localparam logic [1:0] RESP_SHORT       = 2'd1;
    localparam logic [1:0] RESP_LONG        = 2'd2;
    localparam logic [1:0] RESP_SHORT_NOCRC = 2'd3;

    // x^7 + x^3 + 1 with the x^7 term implied
    localparam logic [6:0] CRC7_POLY = 7'h09;

    typedef enum logic [2:0] {
        StIdle,
        StWaitStart,
        StRecv,
        StDone
`ifdef SD_RESP_BUSY_EN
        ,
        StBusyWait
`endif
    } rx_state_e;

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7+x^3+1, init 0), one bit per enabled clock, MSB first.
// Shared between the response receiver and the command transmitter.
module sd_crc7
    import sd_pkg::*;
(
    input  logic       clk,
    input  logic       clear,
    input  logic       en,
    input  logic       bit_in,
    output logic [6:0] crc
);

    logic [6:0] crc_q;
    logic [6:0] crc_d;
    logic       fb;

    always_comb begin
        fb    = bit_in ^ crc_q[6];
        crc_d = crc_q;
        if (clear) begin
            crc_d = '0;
        end else if (en) begin
            crc_d = {crc_q[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
        end
    end

    always_ff @(posedge clk) begin
        crc_q <= crc_d;
    end

    assign crc = crc_q;

endmodule

// File: rtl/sd_resp_rx_param.sv
// SD CMD-line response receiver: NCR wait, 48/136-bit capture, tx/CRC7/end-bit checks.
// Optional SD_RESP_BUSY_EN adds dat0/busy_chk and an R1b busy wait after short frames.
module sd_resp_rx_param
    import sd_pkg::*;
#(
    parameter int unsigned LONG_BITS  = 136,
    parameter int unsigned SHORT_BITS = 48,
    parameter int unsigned NCR_MAX    = 64,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 tick,
    input  logic                 sd_cmd,
    input  logic                 start,
    input  logic [1:0]           resp_type,
    input  logic                 abort,
`ifdef SD_RESP_BUSY_EN
    input  logic                 dat0,
    input  logic                 busy_chk,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [LONG_BITS-1:0] resp,
    output logic                 timeout,
    output logic                 tx_err,
    output logic                 crc_err,
    output logic                 end_err
);

    localparam logic [CNT_W-1:0] LongLast  = CNT_W'(LONG_BITS - 1);
    localparam logic [CNT_W-1:0] ShortLast = CNT_W'(SHORT_BITS - 1);
    localparam logic [CNT_W-1:0] NcrLast   = CNT_W'(NCR_MAX - 1);
    localparam logic [CNT_W-1:0] LongCrcHi = CNT_W'(LONG_BITS - 9);
    localparam logic [CNT_W-1:0] CrcLo     = CNT_W'(8);
    localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

    rx_state_e            state_q, state_d;
    logic [1:0]           type_q, type_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [LONG_BITS-1:0] resp_q, resp_d;
    logic                 timeout_q, timeout_d;
    logic                 tx_err_q, tx_err_d;
    logic                 crc_err_q, crc_err_d;
    logic                 end_err_q, end_err_d;
`ifdef SD_RESP_BUSY_EN
    logic                 busy_chk_q, busy_chk_d;
`endif

    logic                 is_long;
    logic                 crc_checked;
    logic [CNT_W-1:0]     frame_last;
    logic [CNT_W-1:0]     crc_hi;
    logic [CNT_W-1:0]     bit_idx;
    logic                 in_crc_scope;
    logic                 crc_clear;
    logic                 crc_en;
    logic [6:0]           crc_val;

    assign is_long      = (type_q == RESP_LONG);
    assign crc_checked  = (type_q == RESP_SHORT) || (type_q == RESP_LONG);
    assign frame_last   = is_long ? LongLast : ShortLast;
    assign crc_hi       = is_long ? LongCrcHi : ShortLast;
    // cnt_q counts bits still to come, so the bit on the line now is cnt_q-1
    assign bit_idx      = cnt_q - CntOne;
    assign in_crc_scope = (bit_idx >= CrcLo) && (bit_idx <= crc_hi);

    sd_crc7 u_crc (
        .clk    (clk),
        .clear  (crc_clear),
        .en     (crc_en),
        .bit_in (sd_cmd),
        .crc    (crc_val)
    );

    always_comb begin
        state_d   = state_q;
        type_d    = type_q;
        cnt_d     = cnt_q;
        resp_d    = resp_q;
        timeout_d = timeout_q;
        tx_err_d  = tx_err_q;
        crc_err_d = crc_err_q;
        end_err_d = end_err_q;
`ifdef SD_RESP_BUSY_EN
        busy_chk_d = busy_chk_q;
`endif
        crc_clear = ~reset_n;
        crc_en    = 1'b0;

        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        type_d    = resp_type;
                        cnt_d     = '0;
                        resp_d    = '0;
                        timeout_d = 1'b0;
                        tx_err_d  = 1'b0;
                        crc_err_d = 1'b0;
                        end_err_d = 1'b0;
                        crc_clear = 1'b1;
`ifdef SD_RESP_BUSY_EN
                        busy_chk_d = busy_chk;
`endif
                        state_d   = (resp_type == RESP_NONE) ? StDone : StWaitStart;
                    end
                end

                StWaitStart: begin
                    if (tick) begin
                        if (!sd_cmd) begin
                            resp_d  = {resp_q[LONG_BITS-2:0], 1'b0};
                            cnt_d   = frame_last;
                            // long frames exclude the start bit from the CRC
                            crc_en  = ~is_long;
                            state_d = StRecv;
                        end else begin
                            cnt_d = cnt_q + CntOne;
                            if (cnt_q == NcrLast) begin
                                timeout_d = 1'b1;
                                state_d   = StDone;
                            end
                        end
                    end
                end

                StRecv: begin
                    if (tick) begin
                        resp_d = {resp_q[LONG_BITS-2:0], sd_cmd};
                        cnt_d  = cnt_q - CntOne;
                        crc_en = in_crc_scope;
                        if (cnt_q == frame_last && sd_cmd) begin
                            tx_err_d = 1'b1;
                        end
                        if (cnt_q == CntOne) begin
                            end_err_d = ~sd_cmd;
                            crc_err_d = crc_checked && (resp_q[6:0] != crc_val);
                            state_d   = StDone;
`ifdef SD_RESP_BUSY_EN
                            if (busy_chk_q && !is_long) begin
                                state_d = StBusyWait;
                            end
`endif
                        end
                    end
                end

`ifdef SD_RESP_BUSY_EN
                StBusyWait: begin
                    if (tick && dat0) begin
                        state_d = StDone;
                    end
                end
`endif

                StDone: begin
                    state_d = StIdle;
                end

                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            type_q    <= RESP_NONE;
            cnt_q     <= '0;
            resp_q    <= '0;
            timeout_q <= 1'b0;
            tx_err_q  <= 1'b0;
            crc_err_q <= 1'b0;
            end_err_q <= 1'b0;
`ifdef SD_RESP_BUSY_EN
            busy_chk_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            type_q    <= type_d;
            cnt_q     <= cnt_d;
            resp_q    <= resp_d;
            timeout_q <= timeout_d;
            tx_err_q  <= tx_err_d;
            crc_err_q <= crc_err_d;
            end_err_q <= end_err_d;
`ifdef SD_RESP_BUSY_EN
            busy_chk_q <= busy_chk_d;
`endif
        end
    end

    assign busy    = (state_q != StIdle);
    assign done    = (state_q == StDone);
    assign resp    = resp_q;
    assign timeout = timeout_q;
    assign tx_err  = tx_err_q;
    assign crc_err = crc_err_q;
    assign end_err = end_err_q;

endmodule

// File: tb/tb_sd_resp_rx_param.sv
// Self-checking bench for sd_resp_rx_param: vector table, hand-written corner cases and
// randomized frames checked against a polynomial-division reference model.
module tb_sd_resp_rx_param;

    localparam int LB  = 136;
    localparam int SB  = 48;
    localparam int NCR = 64;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          tick;
    logic          sd_cmd;
    logic          start;
    logic [1:0]    resp_type;
    logic          abort;
    logic          busy;
    logic          done;
    logic [LB-1:0] resp;
    logic          timeout;
    logic          tx_err;
    logic          crc_err;
    logic          end_err;
`ifdef SD_RESP_BUSY_EN
    logic          dat0     = 1'b1;
    logic          busy_chk = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    sd_resp_rx_param #(
        .LONG_BITS  (LB),
        .SHORT_BITS (SB),
        .NCR_MAX    (NCR),
        .CNT_W      (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .tick      (tick),
        .sd_cmd    (sd_cmd),
        .start     (start),
        .resp_type (resp_type),
        .abort     (abort),
`ifdef SD_RESP_BUSY_EN
        .dat0      (dat0),
        .busy_chk  (busy_chk),
`endif
        .busy      (busy),
        .done      (done),
        .resp      (resp),
        .timeout   (timeout),
        .tx_err    (tx_err),
        .crc_err   (crc_err),
        .end_err   (end_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    rtype;
        int            idle;
        bit            gaps;
        logic [LB-1:0] frame;
        logic [LB-1:0] exp_resp;
        logic          exp_tx;
        logic          exp_crc;
        logic          exp_end;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Remainder of M(x)*x^7 divided by x^7+x^3+1, M = frame[hi:lo]
    function automatic logic [6:0] crc7_ref(input logic [LB-1:0] frame, input int hi,
                                            input int lo);
        logic [LB+6:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i - lo + 7] = frame[i];
        for (int i = hi - lo + 7; i >= 7; i--) begin
            if (m[i]) m[i -: 8] = m[i -: 8] ^ 8'h89;
        end
        return m[6:0];
    endfunction

    function automatic vec_t model(input logic [1:0] rtype, input int idle,
                                   input logic [LB-1:0] frame, input bit gaps);
        vec_t v;
        int   len;
        int   hi;
        len        = (rtype == 2'd2) ? LB : SB;
        hi         = (rtype == 2'd2) ? LB - 9 : SB - 1;
        v.rtype    = rtype;
        v.idle     = idle;
        v.gaps     = gaps;
        v.frame    = frame;
        v.exp_resp = frame;
        v.exp_tx   = frame[len - 2];
        v.exp_end  = ~frame[0];
        v.exp_crc  = (rtype != 2'd3) && (frame[7:1] != crc7_ref(frame, hi, 8));
        return v;
    endfunction

    task automatic do_start(input logic [1:0] t);
        start     = 1'b1;
        resp_type = t;
        @(posedge clk);
        #1;
        start     = 1'b0;
        resp_type = 2'($urandom);
    endtask

    task automatic tick_bit(input logic b, input bit gaps);
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                tick   = 1'b0;
                sd_cmd = 1'($urandom);
                @(posedge clk);
                #1;
            end
        end
        tick   = 1'b1;
        sd_cmd = b;
        @(posedge clk);
        #1;
        tick   = 1'b0;
        sd_cmd = 1'b1;
    endtask

    task automatic run_and_check(input vec_t v, input string tag, input bit poke);
        int len;
        bit early;
        len   = (v.rtype == 2'd2) ? LB : SB;
        early = 1'b0;
        do_start(v.rtype);
        for (int i = 0; i < v.idle; i++) tick_bit(1'b1, v.gaps);
        for (int i = len - 1; i >= 0; i--) begin
            if (poke && i == len - 10) begin
                start     = 1'b1;
                resp_type = 2'($urandom);
            end
            tick_bit(v.frame[i], v.gaps);
            start = 1'b0;
            if (i > 0 && done) early = 1'b1;
        end
        chk({tag, " done"}, done, 1);
        chk({tag, " early done"}, early, 0);
        chk({tag, " resp"}, resp, v.exp_resp);
        chk({tag, " flags tx/crc/end/to"}, {tx_err, crc_err, end_err, timeout},
            {v.exp_tx, v.exp_crc, v.exp_end, 1'b0});
        @(posedge clk);
        #1;
        chk({tag, " idle after done"}, {busy, done}, 2'b00);
    endtask

    initial begin
        logic [LB-1:0] lf;
        logic [LB-1:0] f;
        logic [1:0]    rt;
        int            found;
        bit            seen;

        reset_n   = 1'b0;
        tick      = 1'b0;
        sd_cmd    = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        resp_type = 2'd0;

        lf          = '0;
        lf[135:128] = 8'h3F;
        lf[127:8]   = 120'h035344534430388012345678_9A0123;
        lf[7:1]     = crc7_ref(lf, 127, 8);
        lf[0]       = 1'b0;

        vecs[0] = '{2'd1, 5, 1'b0, LB'(48'h08000001AA13), LB'(48'h08000001AA13), 0, 0, 0};
        vecs[1] = '{2'd1, 5, 1'b0, LB'(48'h08000001AA15), LB'(48'h08000001AA15), 0, 1, 0};
        vecs[2] = '{2'd3, 0, 1'b0, LB'(48'h3F80FF8000FF), LB'(48'h3F80FF8000FF), 0, 0, 0};
        vecs[3] = '{2'd2, 3, 1'b0, lf, lf, 0, 0, 1};
        vecs[4] = '{2'd3, NCR - 1, 1'b1, LB'(48'h7F80FF8000FE), LB'(48'h7F80FF8000FE), 1, 0, 1};
        f       = lf ^ {{(LB - 8){1'b0}}, 8'h81};
        vecs[5] = '{2'd2, 7, 1'b1, f, f, 0, 1, 0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", {busy, done, timeout, tx_err, crc_err, end_err}, 6'b0);
        chk("reset resp", resp, '0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) run_and_check(vecs[i], $sformatf("vec%0d", i), 1'b0);

        // Timeout: line stays high, a tick on every cycle
        do_start(2'd1);
        tick   = 1'b1;
        sd_cmd = 1'b1;
        found  = -1;
        for (int k = 1; k <= NCR + 4; k++) begin
            @(posedge clk);
            #1;
            if (done && found < 0) found = k;
        end
        tick = 1'b0;
        chk("timeout latency", found, NCR);
        chk("timeout flags", {timeout, tx_err, crc_err, end_err}, 4'b1000);
        chk("timeout resp", resp, '0);

        // No-response command
        do_start(2'd0);
        chk("none done", {done, timeout, crc_err}, 3'b100);
        @(posedge clk);
        #1;
        chk("none idle", {busy, done}, 2'b00);

        // Abort at bit 20 of a long frame
        do_start(2'd2);
        tick_bit(1'b1, 1'b0);
        for (int i = LB - 1; i > 20; i--) tick_bit(lf[i], 1'b0);
        abort  = 1'b1;
        tick   = 1'b1;
        sd_cmd = lf[20];
        @(posedge clk);
        #1;
        abort = 1'b0;
        tick  = 1'b0;
        chk("abort busy", busy, 0);
        seen = 1'b0;
        repeat (5) begin
            if (done) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("abort no done", seen, 0);
        chk("abort resp hold", resp, lf >> 21);
        chk("abort flags", {tx_err, crc_err, end_err, timeout}, 4'b0);

        // Reset at bit 20 of a long frame, then a normal transaction
        do_start(2'd2);
        for (int i = LB - 1; i > 20; i--) tick_bit(lf[i], 1'b0);
        reset_n = 1'b0;
        tick    = 1'b1;
        sd_cmd  = lf[20];
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick    = 1'b0;
        chk("midreset resp", resp, '0);
        chk("midreset busy/done", {busy, done}, 2'b00);
        run_and_check(vecs[0], "post-reset", 1'b0);

        // Randomized frames with tick gaps and stray start pulses
        for (int n = 0; n < 40; n++) begin
            rt = 2'($urandom_range(1, 3));
            f  = '0;
            for (int w = 0; w < 5; w++) f[w*32 +: 32] = $urandom;
            f[LB-1:0] = f[LB-1:0];
            if (rt == 2'd2) begin
                f[135]     = 1'b0;
                f[134]     = ($urandom_range(0, 7) == 0);
                f[133:128] = 6'h3F;
                f[7:1]     = crc7_ref(f, 127, 8);
            end else begin
                f[LB-1:SB] = '0;
                f[47]      = 1'b0;
                f[46]      = ($urandom_range(0, 7) == 0);
                f[7:1]     = crc7_ref(f, 47, 8);
            end
            if ($urandom_range(0, 3) == 0) f[7:1] = f[7:1] ^ 7'($urandom_range(1, 127));
            f[0] = ($urandom_range(0, 7) != 0);
            run_and_check(model(rt, $urandom_range(0, NCR - 1), f, 1'b1),
                          $sformatf("rand%0d", n), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
